// File: rtl/branch_resolve_unit.sv
// Multi-lane branch/jump resolution with registered per-lane results and an
// age-arbitrated, held redirect towards fetch/recovery.

module branch_resolve_lane #(
    parameter int SIZE_DATA = 32,
    parameter int SIZE_PC   = 32,
    parameter int SIZE_IMM  = 20
) (
    input  logic [2:0]           op,
    input  logic [SIZE_DATA-1:0] data1,
    input  logic [SIZE_DATA-1:0] data2,
    input  logic [SIZE_IMM-1:0]  immd,
    input  logic [SIZE_PC-1:0]   pc,
    input  logic [SIZE_PC-1:0]   pred_npc,
    input  logic                 pred_dir,
    output logic                 taken,
    output logic [SIZE_PC-1:0]   next_pc,
    output logic [SIZE_PC-1:0]   result,
    output logic                 misp
);
    localparam logic [2:0] OP_JAL  = 3'd2;
    localparam logic [2:0] OP_JALR = 3'd3;

    logic [SIZE_PC-1:0] imm_ext, pc_plus4, br_tgt, jalr_tgt;
    logic               cmp;

    assign imm_ext  = SIZE_PC'($signed(immd));
    assign pc_plus4 = pc + SIZE_PC'(4);
    assign br_tgt   = pc + imm_ext;
    assign jalr_tgt = (data1[SIZE_PC-1:0] + imm_ext) & ~SIZE_PC'(1);

    always_comb begin
        cmp = 1'b0;
        case (op)
            3'd0:    cmp = (data1 == data2);
            3'd1:    cmp = (data1 != data2);
            3'd4:    cmp = ($signed(data1) <  $signed(data2));
            3'd5:    cmp = ($signed(data1) >= $signed(data2));
            3'd6:    cmp = (data1 <  data2);
            3'd7:    cmp = (data1 >= data2);
            default: cmp = 1'b0;
        endcase
    end

    // A correctly predicted taken branch must also have predicted the right target.
    always_comb begin
        taken   = cmp;
        next_pc = cmp ? br_tgt : pc_plus4;
        result  = '0;
        misp    = (cmp != pred_dir) || (cmp && pred_dir && (pred_npc != br_tgt));
        if (op == OP_JAL) begin
            taken   = 1'b1;
            next_pc = pred_npc;
            result  = pc_plus4;
            misp    = 1'b0;
        end else if (op == OP_JALR) begin
            taken   = 1'b1;
            next_pc = jalr_tgt;
            result  = pc_plus4;
            misp    = (jalr_tgt != pred_npc);
        end
    end
endmodule

module branch_resolve_unit #(
    parameter int NUM_LANES = 2,
    parameter int SIZE_DATA = 32,
    parameter int SIZE_PC   = 32,
    parameter int SIZE_IMM  = 20,
    parameter int ROB_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          flush_i,
    input  logic [$clog2(ROB_DEPTH)-1:0]                  robHead_i,
    input  logic [NUM_LANES-1:0]                          valid_i,
    input  logic [NUM_LANES-1:0][2:0]                     op_i,
    input  logic [NUM_LANES-1:0][SIZE_DATA-1:0]           data1_i,
    input  logic [NUM_LANES-1:0][SIZE_DATA-1:0]           data2_i,
    input  logic [NUM_LANES-1:0][SIZE_IMM-1:0]            immd_i,
    input  logic [NUM_LANES-1:0][SIZE_PC-1:0]             pc_i,
    input  logic [NUM_LANES-1:0][SIZE_PC-1:0]             predNPC_i,
    input  logic [NUM_LANES-1:0]                          predDir_i,
    input  logic [NUM_LANES-1:0][$clog2(ROB_DEPTH)-1:0]   robId_i,
    output logic [NUM_LANES-1:0]                          resValid_o,
    output logic [NUM_LANES-1:0][SIZE_PC-1:0]             result_o,
    output logic [NUM_LANES-1:0][SIZE_PC-1:0]             nextPC_o,
    output logic [NUM_LANES-1:0]                          direction_o,
    output logic [NUM_LANES-1:0]                          mispredict_o,
    output logic                                          redirValid_o,
    output logic [SIZE_PC-1:0]                            redirPC_o,
    output logic [$clog2(ROB_DEPTH)-1:0]                  redirRobId_o,
    input  logic                                          redirReady_i,
    output logic [CNT_W-1:0]                              mispCount_o
);
    localparam int ROB_W = $clog2(ROB_DEPTH);
    localparam int SUM_W = CNT_W + $clog2(NUM_LANES + 1);

    typedef struct packed {
        logic [SIZE_PC-1:0] pc;
        logic [ROB_W-1:0]   rob_id;
    } redir_t;

    typedef enum logic {IDLE, PEND} state_t;

    logic [NUM_LANES-1:0]              l_taken, l_misp, lane_live;
    logic [NUM_LANES-1:0][SIZE_PC-1:0] l_npc, l_res;
    logic [NUM_LANES-1:0][ROB_W-1:0]   lane_age;

    assign lane_live = valid_i & ~{NUM_LANES{flush_i}};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        branch_resolve_lane #(
            .SIZE_DATA(SIZE_DATA), .SIZE_PC(SIZE_PC), .SIZE_IMM(SIZE_IMM)
        ) u_lane (
            .op(op_i[g]), .data1(data1_i[g]), .data2(data2_i[g]), .immd(immd_i[g]),
            .pc(pc_i[g]), .pred_npc(predNPC_i[g]), .pred_dir(predDir_i[g]),
            .taken(l_taken[g]), .next_pc(l_npc[g]), .result(l_res[g]), .misp(l_misp[g])
        );
        // Modulo distance from the head: smaller means older, wrap-safe.
        assign lane_age[g] = robId_i[g] - robHead_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resValid_o   <= '0;
            direction_o  <= '0;
            mispredict_o <= '0;
            nextPC_o     <= '0;
            result_o     <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                resValid_o[i]   <= lane_live[i];
                direction_o[i]  <= lane_live[i] & l_taken[i];
                mispredict_o[i] <= lane_live[i] & l_misp[i];
                nextPC_o[i]     <= lane_live[i] ? l_npc[i] : '0;
                result_o[i]     <= lane_live[i] ? l_res[i] : '0;
            end
        end
    end

    // Oldest mispredicting lane; strict compare keeps the lowest lane on a tie.
    logic             cand_vld;
    logic [ROB_W-1:0] cand_age;
    redir_t           cand;

    always_comb begin
        cand_vld = 1'b0;
        cand_age = '0;
        cand     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_live[i] && l_misp[i] && (!cand_vld || lane_age[i] < cand_age)) begin
                cand_vld    = 1'b1;
                cand_age    = lane_age[i];
                cand.pc     = l_npc[i];
                cand.rob_id = robId_i[i];
            end
        end
    end

    state_t           state_q, state_d;
    redir_t           redir_q, redir_d;
    logic [ROB_W-1:0] held_age;

    assign held_age = redir_q.rob_id - robHead_i;

    always_comb begin
        state_d = state_q;
        redir_d = redir_q;
        if (flush_i) begin
            state_d = IDLE;
            redir_d = '0;
        end else begin
            case (state_q)
                IDLE: if (cand_vld) begin
                    state_d = PEND;
                    redir_d = cand;
                end
                PEND: if (redirReady_i) begin
                    if (cand_vld) begin
                        redir_d = cand;
                    end else begin
                        state_d = IDLE;
                        redir_d = '0;
                    end
                end else if (cand_vld && cand_age < held_age) begin
                    redir_d = cand;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
        end
    end

    assign redirValid_o = (state_q == PEND);
    assign redirPC_o    = redir_q.pc;
    assign redirRobId_o = redir_q.rob_id;

    logic [SUM_W-1:0] cnt_sum;

    always_comb begin
        cnt_sum = SUM_W'(mispCount_o);
        for (int i = 0; i < NUM_LANES; i++)
            cnt_sum = cnt_sum + SUM_W'(lane_live[i] & l_misp[i]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            mispCount_o <= '0;
        else if (cnt_sum > SUM_W'({CNT_W{1'b1}}))
            mispCount_o <= '1;
        else
            mispCount_o <= cnt_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares each cycle.

module tb_branch_resolve_unit;
    localparam int NL = 2;

    logic                  clk = 1'b0;
    logic                  reset, flush_i, redirReady_i;
    logic [5:0]            robHead_i;
    logic [NL-1:0]         valid_i, predDir_i;
    logic [NL-1:0][2:0]    op_i;
    logic [NL-1:0][31:0]   data1_i, data2_i, pc_i, predNPC_i;
    logic [NL-1:0][19:0]   immd_i;
    logic [NL-1:0][5:0]    robId_i;

    logic [NL-1:0]         resValid_o, direction_o, mispredict_o;
    logic [NL-1:0][31:0]   result_o, nextPC_o;
    logic                  redirValid_o;
    logic [31:0]           redirPC_o, mispCount_o;
    logic [5:0]            redirRobId_o;

    logic [NL-1:0]         s_resValid, s_direction, s_mispredict;
    logic [NL-1:0][31:0]   s_result, s_nextPC;
    logic                  s_redirValid;
    logic [31:0]           s_redirPC;
    logic [5:0]            s_redirRobId;
    logic [1:0]            s_mispCount;

    always #5 clk = ~clk;

    branch_resolve_unit u_dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .robHead_i(robHead_i),
        .valid_i(valid_i), .op_i(op_i), .data1_i(data1_i), .data2_i(data2_i),
        .immd_i(immd_i), .pc_i(pc_i), .predNPC_i(predNPC_i), .predDir_i(predDir_i),
        .robId_i(robId_i), .resValid_o(resValid_o), .result_o(result_o),
        .nextPC_o(nextPC_o), .direction_o(direction_o), .mispredict_o(mispredict_o),
        .redirValid_o(redirValid_o), .redirPC_o(redirPC_o), .redirRobId_o(redirRobId_o),
        .redirReady_i(redirReady_i), .mispCount_o(mispCount_o)
    );

    branch_resolve_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .flush_i(flush_i), .robHead_i(robHead_i),
        .valid_i(valid_i), .op_i(op_i), .data1_i(data1_i), .data2_i(data2_i),
        .immd_i(immd_i), .pc_i(pc_i), .predNPC_i(predNPC_i), .predDir_i(predDir_i),
        .robId_i(robId_i), .resValid_o(s_resValid), .result_o(s_result),
        .nextPC_o(s_nextPC), .direction_o(s_direction), .mispredict_o(s_mispredict),
        .redirValid_o(s_redirValid), .redirPC_o(s_redirPC), .redirRobId_o(s_redirRobId),
        .redirReady_i(redirReady_i), .mispCount_o(s_mispCount)
    );

    typedef struct packed {
        logic [NL-1:0]       rv, dir, misp;
        logic [NL-1:0][31:0] npc, res;
        logic                rvld;
        logic [31:0]         rpc;
        logic [5:0]          rrob;
        logic [31:0]         cnt;
        logic [1:0]          cnt2;
    } exp_t;

    exp_t   q[$];
    int     ncmp = 0, nerr = 0;
    logic   m_vld;
    logic [31:0] m_pc;
    logic [5:0]  m_rob;
    longint m_cnt;
    int     m_cnt2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int age(input logic [5:0] id, input logic [5:0] head);
        return (int'(id) - int'(head) + 64) % 64;
    endfunction

    function automatic void ref_lane(input logic [2:0] op, input logic [31:0] d1, d2,
                                     input logic [19:0] imm, input logic [31:0] pc, pnpc,
                                     input logic pd, output logic t, output logic [31:0] npc,
                                     output logic [31:0] res, output logic m);
        logic [31:0] se;
        se = {{12{imm[19]}}, imm};
        case (op)
            3'd0: t = (d1 == d2);
            3'd1: t = (d1 != d2);
            3'd4: t = ($signed(d1) < $signed(d2));
            3'd5: t = !($signed(d1) < $signed(d2));
            3'd6: t = (d1 < d2);
            3'd7: t = !(d1 < d2);
            default: t = 1'b1;
        endcase
        if (op == 3'd2) begin
            npc = pnpc; res = pc + 32'd4; m = 1'b0;
        end else if (op == 3'd3) begin
            npc = (d1 + se) & 32'hFFFF_FFFE; res = pc + 32'd4; m = (npc != pnpc);
        end else begin
            npc = t ? pc + se : pc + 32'd4; res = 32'd0;
            m = (t != pd) || (t && pnpc != pc + se);
        end
    endfunction

    // Applies the current inputs to the model, queues the expected post-edge state, advances one cycle.
    task automatic step();
        exp_t e;
        int best;
        logic t, m;
        logic [31:0] npc, res;
        e = '0;
        best = -1;
        if (reset) begin
            m_vld = 0; m_pc = 0; m_rob = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (flush_i) begin
            m_vld = 0; m_pc = 0; m_rob = 0;
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (valid_i[l]) begin
                    ref_lane(op_i[l], data1_i[l], data2_i[l], immd_i[l], pc_i[l],
                             predNPC_i[l], predDir_i[l], t, npc, res, m);
                    e.rv[l] = 1'b1; e.dir[l] = t; e.misp[l] = m;
                    e.npc[l] = npc; e.res[l] = res;
                    if (m) begin
                        if (m_cnt < 64'd4294967295) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                        if (best < 0 || age(robId_i[l], robHead_i) < age(robId_i[best], robHead_i))
                            best = l;
                    end
                end
            end
            if (best >= 0 && (!m_vld || redirReady_i ||
                              age(robId_i[best], robHead_i) < age(m_rob, robHead_i))) begin
                m_vld = 1; m_pc = e.npc[best]; m_rob = robId_i[best];
            end else if (m_vld && redirReady_i) begin
                m_vld = 0; m_pc = 0; m_rob = 0;
            end
        end
        e.rvld = m_vld; e.rpc = m_pc; e.rrob = m_rob;
        e.cnt = 32'(m_cnt); e.cnt2 = 2'(m_cnt2);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush_i = 0; valid_i = '0; predDir_i = '0; op_i = '0;
        data1_i = '0; data2_i = '0; pc_i = '0; predNPC_i = '0; immd_i = '0; robId_i = '0;
    endtask

    task automatic set_lane(input int l, input logic [2:0] op, input logic [31:0] d1, d2,
                            input logic [19:0] imm, input logic [31:0] pc, pnpc,
                            input logic pd, input logic [5:0] rob);
        valid_i[l] = 1'b1; op_i[l] = op; data1_i[l] = d1; data2_i[l] = d2; immd_i[l] = imm;
        pc_i[l] = pc; predNPC_i[l] = pnpc; predDir_i[l] = pd; robId_i[l] = rob;
    endtask

    // Mispredicting BEQ: equal operands, predicted not-taken.
    task automatic misp_op(input int l, input logic [5:0] rob);
        set_lane(l, 3'd0, 32'd9, 32'd9, 20'h40, 32'h1000 + 32'(rob) * 4, 32'd0, 1'b0, rob);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("resValid",   64'(resValid_o),   64'(e.rv));
                chk("direction",  64'(direction_o),  64'(e.dir));
                chk("mispredict", 64'(mispredict_o), 64'(e.misp));
                chk("nextPC",     64'(nextPC_o),     64'(e.npc));
                chk("result",     64'(result_o),     64'(e.res));
                chk("redirValid", 64'(redirValid_o), 64'(e.rvld));
                chk("redirPC",    64'(redirPC_o),    64'(e.rpc));
                chk("redirRobId", 64'(redirRobId_o), 64'(e.rrob));
                chk("mispCount",  64'(mispCount_o),  64'(e.cnt));
                chk("mispCountSat", 64'(s_mispCount), 64'(e.cnt2));
            end
        end
    end

    initial begin : stim
        logic [31:0] se, tgt;
        int r;
        reset = 1; redirReady_i = 0; robHead_i = '0;
        idle_inputs();
        step(); step();
        reset = 0;
        chk("rst_redirValid", 64'(redirValid_o), 64'd0);
        chk("rst_count", 64'(mispCount_o), 64'd0);

        // Signed vs unsigned compare; saturation of the narrow counter
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            set_lane(0, 3'd4, 32'hFFFF_FFFF, 32'd1, 20'h10, 32'h200, 32'd0, 1'b0, 6'd7);
            set_lane(1, 3'd6, 32'hFFFF_FFFF, 32'd1, 20'h10, 32'h204, 32'h208, 1'b0, 6'd8);
            step();
        end
        chk("blt_taken", 64'(direction_o[0]), 64'd1);
        chk("bltu_not_taken", 64'(direction_o[1]), 64'd0);
        chk("sat_count", 64'(s_mispCount), 64'd3);
        chk("count5", 64'(mispCount_o), 64'd5);
        idle_inputs(); redirReady_i = 1; step(); redirReady_i = 0;

        // BEQ taken, predicted not-taken
        idle_inputs();
        set_lane(0, 3'd0, 32'd5, 32'd5, 20'h20, 32'h100, 32'h104, 1'b0, 6'd3);
        step();
        chk("beq_npc", 64'(nextPC_o[0]), 64'h120);
        chk("beq_redirPC", 64'(redirPC_o), 64'h120);
        idle_inputs(); redirReady_i = 1; step(); redirReady_i = 0;

        // JALR clears bit 0 and is predicted correctly
        idle_inputs();
        set_lane(0, 3'd3, 32'h2003, 32'd0, 20'h0, 32'h300, 32'h2002, 1'b1, 6'd4);
        step();
        chk("jalr_npc", 64'(nextPC_o[0]), 64'h2002);
        chk("jalr_link", 64'(result_o[0]), 64'h304);
        chk("jalr_no_redir", 64'(redirValid_o), 64'd0);

        // ROB wrap: head 62, id 63 older than id 1
        idle_inputs(); robHead_i = 6'd62;
        misp_op(0, 6'd1); misp_op(1, 6'd63);
        step();
        chk("wrap_rob", 64'(redirRobId_o), 64'd63);
        idle_inputs(); redirReady_i = 1; step(); redirReady_i = 0;

        // Held redirect: older replaces, younger is dropped
        robHead_i = 6'd0;
        idle_inputs(); misp_op(0, 6'd10); step();
        idle_inputs(); step(); step(); step();
        chk("held_rob", 64'(redirRobId_o), 64'd10);
        idle_inputs(); misp_op(1, 6'd5); step();
        chk("older_rob", 64'(redirRobId_o), 64'd5);
        idle_inputs(); misp_op(0, 6'd20); step();
        chk("younger_drop", 64'(redirRobId_o), 64'd5);
        idle_inputs(); redirReady_i = 1; step(); redirReady_i = 0;
        chk("handshake_clr", 64'(redirValid_o), 64'd0);

        // Flush beats a pending redirect and a new mispredict
        idle_inputs(); misp_op(0, 6'd12); step();
        r = int'(mispCount_o);
        idle_inputs(); flush_i = 1; misp_op(0, 6'd2); step();
        chk("flush_redir", 64'(redirValid_o), 64'd0);
        chk("flush_resv", 64'(resValid_o), 64'd0);
        chk("flush_count", 64'(mispCount_o), 64'(r));
        idle_inputs();

        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            robHead_i = 6'($urandom);
            redirReady_i = $urandom_range(0, 1) == 1;
            flush_i = $urandom_range(0, 15) == 0;
            robId_i[0] = 6'($urandom);
            robId_i[1] = robId_i[0] + 6'($urandom_range(1, 63));
            for (int l = 0; l < NL; l++) begin
                valid_i[l]   = $urandom_range(0, 3) != 0;
                op_i[l]      = 3'($urandom);
                data1_i[l]   = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom_range(0, 40));
                data2_i[l]   = $urandom_range(0, 3) == 0 ? data1_i[l] : 32'($urandom_range(0, 40));
                immd_i[l]    = 20'($urandom);
                pc_i[l]      = $urandom & 32'hFFFF_FFFC;
                predDir_i[l] = $urandom_range(0, 1) == 1;
                se  = {{12{immd_i[l][19]}}, immd_i[l]};
                tgt = (op_i[l] == 3'd3) ? ((data1_i[l] + se) & 32'hFFFF_FFFE) : pc_i[l] + se;
                r = $urandom_range(0, 2);
                predNPC_i[l] = (r == 0) ? tgt : (r == 1) ? pc_i[l] + 32'd4 : $urandom;
            end
            step();
        end

        idle_inputs(); redirReady_i = 1;
        step(); step();
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Multi-lane, registered successor to the single-lane combinational control ALU.
- Resolves up to NUM_LANES branches/jumps per cycle: direction, target and mispredict per lane.
- Arbitrates mispredicts by ROB age into one held redirect with a valid/ready handshake to fetch/recovery.
- Sits in the execute stage between the control-op issue lanes and the front-end redirect path.

Parameters:
NUM_LANES, 2, control ops accepted per cycle
SIZE_DATA, 32, operand width
SIZE_PC, 32, PC width (≤ SIZE_DATA)
SIZE_IMM, 20, immediate width, sign-extended
ROB_DEPTH, 64, ROB entries (power of 2)
CNT_W, 32, mispredict counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush_i  in  1  pipeline recovery; squash everything
robHead_i  in  log2(ROB_DEPTH)  current ROB head, age reference
valid_i  in  NUM_LANES  lane op valid
op_i  in  NUM_LANES*3  0 BEQ,1 BNE,2 JAL,3 JALR,4 BLT,5 BGE,6 BLTU,7 BGEU
data1_i / data2_i  in  NUM_LANES*SIZE_DATA  source operands
immd_i  in  NUM_LANES*SIZE_IMM  immediate
pc_i / predNPC_i  in  NUM_LANES*SIZE_PC  op PC, predicted next PC
predDir_i  in  NUM_LANES  predicted direction
robId_i  in  NUM_LANES*log2(ROB_DEPTH)  ROB index
resValid_o  out  NUM_LANES  result valid (1-cycle latency)
result_o  out  NUM_LANES*SIZE_PC  link value pc+4 (JAL/JALR), else 0
nextPC_o  out  NUM_LANES*SIZE_PC  resolved next PC
direction_o / mispredict_o  out  NUM_LANES  resolved taken; lane mispredict
redirValid_o  out  1  redirect pending
redirPC_o  out  SIZE_PC  redirect target
redirRobId_o  out  log2(ROB_DEPTH)  ROB id of mispredicting op
redirReady_i  in  1  consumer accepts redirect
mispCount_o  out  CNT_W  saturating mispredict counter

Behaviour:
- Reset (sync, high): all outputs 0; pending redirect cleared; counter 0.
- Resolution (per lane, combinational, registered at clk → 1-cycle latency):
  - taken = compare of data1/data2: EQ/NE, signed LT/GE, unsigned LTU/GEU.
  - Branch: nextPC = taken ? pc+sext(imm) : pc+4. Mispredict if taken≠predDir, or taken && predDir && predNPC≠pc+sext(imm).
  - JAL: taken=1, nextPC=predNPC, mispredict=0, result=pc+4.
  - JALR: taken=1, nextPC=(data1+sext(imm)) with bit0 cleared, mispredict=(nextPC≠predNPC), result=pc+4.
  - All adds truncate modulo 2^SIZE_PC.
- Lane output registers load every cycle. resValid_o = registered valid_i & ~flush_i. Invalid lanes output zeros.
- Age = (robId − robHead_i) mod ROB_DEPTH; smaller = older. Ages are computed in the input cycle; the stored redirect age is recomputed each cycle against the live robHead_i.
- Redirect register holds {PC, robId}. Candidate = oldest mispredicting valid lane this cycle; ties are impossible (unique robIds), lowest lane index wins if violated.
- Redirect FSM:
  - IDLE: a candidate loads → PEND (redirValid_o=1 the next cycle).
  - PEND: redirValid_o && redirReady_i → handshake done. If a new candidate arrives in the same cycle, it loads and stays PEND; otherwise → IDLE.
  - PEND, no handshake, candidate older than held: replace held. Younger or equal: drop (those ops are squashed by the held redirect).
  - redirPC_o/redirRobId_o stable while PEND and not replaced.
- flush_i: highest priority. Clears redirect (→ IDLE) and zeroes resValid_o next cycle. Input candidates in the flush cycle are ignored.
- mispCount_o: +number of mispredicting valid lanes per cycle (not flushed); saturates at all-ones.
- ROB wrap: robId < robHead_i is correctly older/younger per the modulo age, e.g. head=62, id 1 is younger than id 63.

Test Plan:
1. Lane0 BEQ data1=data2=5, pc=0x100, imm=0x20, predDir=0 → next cycle resValid=1, dir=1, nextPC=0x120, misp=1; redirValid=1, redirPC=0x120.
2. JALR data1=0x2003, imm=0, predNPC=0x2002 → nextPC=0x2002, result=pc+4, misp=0, no redirect.
3. Head=62: lane0 robId=1 misp, lane1 robId=63 misp same cycle → redirRobId=63.
4. redirReady=0 hold 3 cycles with held robId=10; inject older robId=5 misp → replaced by 5; inject robId=20 → ignored; assert ready → cleared next cycle.
5. flush_i during PEND with new misp input → next cycle redirValid=0, resValid=0; counter unchanged by the flushed input.
6. BLT data1=0xFFFFFFFF, data2=1 → taken; BLTU same operands → not-taken; CNT_W=2 with 5 mispredicts → mispCount_o=3.
